// File: rtl/carry_resp_checker.sv
// Response checker for the carry (majority) cell: compares each accepted cout against maj(a,b,c).
// Optional CARRY_CHK_ORDER_EN also flags samples whose {a,b,c} is not index mod 8.
module carry_resp_checker #(
    parameter int NUM_VEC = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             in_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] NV   = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VEC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] acc_cnt;
    logic             stg_vld, stg_a, stg_b, stg_c, stg_cout;
    logic [CNT_W-1:0] stg_idx;
    logic             accept, clr, exp_cout, mismatch, last_cmp;

    // in_ready depends only on registered state, never on in_valid
    assign in_ready = (state == RUN) && (acc_cnt < NV);
    assign accept   = in_valid && in_ready;
    assign clr      = start && (state != RUN);
    assign exp_cout = (stg_a & stg_b) | (stg_a & stg_c) | (stg_b & stg_c);
    assign last_cmp = stg_vld && (stg_idx == LAST);

`ifdef CARRY_CHK_ORDER_EN
    logic [2:0] ord_exp;
    assign ord_exp  = 3'(stg_idx);
    assign mismatch = (stg_cout != exp_cout) || ({stg_a, stg_b, stg_c} != ord_exp);
`else
    assign mismatch = (stg_cout != exp_cout);
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // start during RUN is ignored, including on the final compare edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_cmp) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt         <= '0;
            stg_vld         <= 1'b0;
            stg_a           <= 1'b0;
            stg_b           <= 1'b0;
            stg_c           <= 1'b0;
            stg_cout        <= 1'b0;
            stg_idx         <= '0;
            err_count       <= '0;
            vec_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (clr) begin
            acc_cnt         <= '0;
            stg_vld         <= 1'b0;
            err_count       <= '0;
            vec_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            stg_vld <= accept;
            if (accept) begin
                stg_a    <= in_a;
                stg_b    <= in_b;
                stg_c    <= in_c;
                stg_cout <= in_cout;
                stg_idx  <= acc_cnt;
                acc_cnt  <= acc_cnt + 1'b1;
            end
            if (stg_vld) begin
                vec_count <= vec_count + 1'b1;
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= stg_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_carry_resp_checker.sv
// Directed bench for carry_resp_checker: main instance (NUM_VEC=8) plus a CNT_W=3 saturation instance.
module tb_carry_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, s_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_a = 1'b0, in_b = 1'b0, in_c = 1'b0, in_cout = 1'b0;

    logic       in_ready, busy, done, pass, first_err_valid;
    logic [7:0] err_count, vec_count, first_err_idx;
    logic       s_in_ready, s_busy, s_done, s_pass, s_fev;
    logic [2:0] s_err, s_vec, s_fei;

    int cmp_n = 0;
    int err_n = 0;

    always #5 clk = ~clk;

    carry_resp_checker #(.NUM_VEC(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_cout(in_cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_count(vec_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    carry_resp_checker #(.NUM_VEC(7), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_cout(in_cout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err), .vec_count(s_vec),
        .first_err_valid(s_fev), .first_err_idx(s_fei)
    );

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) s_start = 1'b1; else start = 1'b1;
        tick();
        start   = 1'b0;
        s_start = 1'b0;
    endtask

    // ops packs operand i at [3*i +: 3]; flip[i] inverts the correct cout of vector i
    task automatic run_stream(input bit sel, input int n, input logic [23:0] ops,
                              input logic [7:0] flip, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
                tick();
                cmp_n++;
                if (vec_count !== 8'(i)) begin
                    err_n++;
                    $display("FAIL gap_vec_count[%0d]: got %0d want %0d", i, vec_count, i);
                end
            end
            {in_a, in_b, in_c} = ops[3*i +: 3];
            in_cout  = maj(ops[3*i +: 3]) ^ flip[i];
            in_valid = 1'b1;
            for (int t = 0; t < 20 && !(sel ? s_in_ready : in_ready); t++) tick();
            if (!(sel ? s_in_ready : in_ready)) begin
                cmp_n++;
                err_n++;
                $display("FAIL ready_timeout[%0d]: got 0 want 1", i);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_final(input string nm, input logic e_pass, input logic [7:0] e_err,
                               input logic e_fev, input logic [7:0] e_fei);
        cmp_n++; if (done !== 1'b1) begin err_n++; $display("FAIL %s_done: got %0b want 1", nm, done); end
        cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL %s_busy: got %0b want 0", nm, busy); end
        cmp_n++; if (pass !== e_pass) begin err_n++; $display("FAIL %s_pass: got %0b want %0b", nm, pass, e_pass); end
        cmp_n++; if (vec_count !== 8'd8) begin err_n++; $display("FAIL %s_vec: got %0d want 8", nm, vec_count); end
        cmp_n++; if (err_count !== e_err) begin err_n++; $display("FAIL %s_err: got %0d want %0d", nm, err_count, e_err); end
        cmp_n++; if (first_err_valid !== e_fev) begin err_n++; $display("FAIL %s_fev: got %0b want %0b", nm, first_err_valid, e_fev); end
        cmp_n++; if (first_err_idx !== e_fei) begin err_n++; $display("FAIL %s_fei: got %0d want %0d", nm, first_err_idx, e_fei); end
    endtask

    task automatic check_all_zero(input string nm);
        cmp_n++;
        if ({in_ready, busy, done, pass, first_err_valid} !== 5'b0 ||
            err_count !== 8'd0 || vec_count !== 8'd0 || first_err_idx !== 8'd0) begin
            err_n++;
            $display("FAIL %s_zero: got rdy=%0b busy=%0b done=%0b pass=%0b err=%0d vec=%0d fev=%0b fei=%0d want all 0",
                     nm, in_ready, busy, done, pass, err_count, vec_count, first_err_valid, first_err_idx);
        end
    endtask

    localparam logic [23:0] ASC  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] SWAP = {3'd7, 3'd6, 3'd2, 3'd4, 3'd3, 3'd5, 3'd1, 3'd0};

    task automatic test_reset();
        check_all_zero("reset");
        cmp_n++;
        if ({s_in_ready, s_busy, s_done, s_pass, s_fev} !== 5'b0 || s_err !== 3'd0 || s_vec !== 3'd0) begin
            err_n++;
            $display("FAIL reset_sat: got nonzero outputs want all 0");
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cmp_n++; if (vec_count !== 8'd0) begin err_n++; $display("FAIL idle_no_accept: got %0d want 0", vec_count); end
    endtask

    task automatic test_back_to_back();
        pulse_start(1'b0);
        cmp_n++; if (busy !== 1'b1 || in_ready !== 1'b1) begin err_n++; $display("FAIL b2b_run: got busy=%0b rdy=%0b want 1 1", busy, in_ready); end
        run_stream(1'b0, 8, ASC, 8'h00, 1'b0);
        cmp_n++; if (in_ready !== 1'b0) begin err_n++; $display("FAIL b2b_ready_drop: got %0b want 0", in_ready); end
        cmp_n++; if (vec_count !== 8'd7 || done !== 1'b0) begin err_n++; $display("FAIL b2b_latency: got vec=%0d done=%0b want 7 0", vec_count, done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        check_final("b2b", 1'b1, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic test_error();
        pulse_start(1'b0);
        run_stream(1'b0, 8, ASC, 8'h08, 1'b0);
        tick();
        check_final("err", 1'b0, 8'd1, 1'b1, 8'd3);
    endtask

    task automatic test_gaps();
        pulse_start(1'b0);
        run_stream(1'b0, 8, ASC, 8'h00, 1'b1);
        cmp_n++; if (in_ready !== 1'b0) begin err_n++; $display("FAIL gap_ready_drop: got %0b want 0", in_ready); end
        tick();
        check_final("gap", 1'b1, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic test_saturation();
        pulse_start(1'b1);
        run_stream(1'b1, 7, ASC, 8'h7F, 1'b0);
        tick();
        cmp_n++; if (s_err !== 3'd7) begin err_n++; $display("FAIL sat_err: got %0d want 7", s_err); end
        cmp_n++; if (s_fev !== 1'b1 || s_fei !== 3'd0) begin err_n++; $display("FAIL sat_first: got fev=%0b fei=%0d want 1 0", s_fev, s_fei); end
        cmp_n++; if (s_done !== 1'b1 || s_pass !== 1'b0 || s_vec !== 3'd7) begin err_n++; $display("FAIL sat_done: got done=%0b pass=%0b vec=%0d want 1 0 7", s_done, s_pass, s_vec); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(1'b0);
        run_stream(1'b0, 4, ASC, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        check_all_zero("midrst_hold");
        #2 rst_n = 1'b1;
        tick();
        pulse_start(1'b0);
        run_stream(1'b0, 8, ASC, 8'h00, 1'b0);
        tick();
        check_final("after_rst", 1'b1, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic test_swap_order();
        pulse_start(1'b0);
        run_stream(1'b0, 8, SWAP, 8'h00, 1'b0);
        tick();
`ifdef CARRY_CHK_ORDER_EN
        check_final("swap", 1'b0, 8'd2, 1'b1, 8'd2);
`else
        check_final("swap", 1'b1, 8'd0, 1'b0, 8'd0);
`endif
    endtask

    initial begin
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_back_to_back();
        test_error();
        test_gaps();
        test_saturation();
        test_reset_mid_run();
        test_swap_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
